// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: lane width, modulus and tile reorder modes.
package ntt_pkg;

  localparam int          WIDTH      = 32;
  localparam logic [22:0] Q          = 23'd8380417;
  localparam int          TILE_BEATS = 4;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_TRANS    = 2'b01;
  localparam logic [1:0] MODE_TRANS_BR = 2'b10;

  function automatic logic [1:0] bitRev2(input logic [1:0] idx);
    return {idx[0], idx[1]};
  endfunction

endpackage

// File: rtl/coef_tile_bank.sv
// One 4x4 coefficient tile: row-wise write port, combinational reordered read of one beat.
// Read is zero-latency from registers; the tile mode is latched with row 0.
module coef_tile_bank
  import ntt_pkg::*;
#(
  parameter int WIDTH = ntt_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wrEn,
  input  logic [1:0]           wrRow,
  input  logic [4*WIDTH-1:0]   wrData,
  input  logic [1:0]           wrMode,
  input  logic [1:0]           rdBeat,
  output logic [4*WIDTH-1:0]   rdData
);

  logic [WIDTH-1:0] mem [TILE_BEATS][TILE_BEATS];
  logic [1:0]       mode;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int c = 0; c < TILE_BEATS; c++) begin
        mem[wrRow][c] <= wrData[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_PASS;
    end else if (wrEn && wrRow == 2'd0) begin
      mode <= wrMode;
    end
  end

  // Encoding 11 is unassigned and falls back to pass-through.
  always_comb begin
    rdData = '0;
    for (int j = 0; j < TILE_BEATS; j++) begin
      case (mode)
        MODE_TRANS:    rdData[j*WIDTH +: WIDTH] = mem[2'(j)][rdBeat];
        MODE_TRANS_BR: rdData[j*WIDTH +: WIDTH] = mem[bitRev2(2'(j))][rdBeat];
        default:       rdData[j*WIDTH +: WIDTH] = mem[rdBeat][2'(j)];
      endcase
    end
  end

endmodule

// File: rtl/coef_tile_unpack.sv
// Ping-pong 4x4 tile reorder buffer; first beat out one cycle after a tile's last beat in.
// Input stalls only while the bank being written is still full; output holds data while stalled.
module coef_tile_unpack
  import ntt_pkg::*;
#(
  parameter int          WIDTH = ntt_pkg::WIDTH,
  parameter logic [22:0] Q     = ntt_pkg::Q
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WIDTH-1:0]   in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [1:0] LastBeat = 2'(TILE_BEATS - 1);

  logic [1:0]         full, fullNext;
  logic               wrBank, rdBank;
  logic [1:0]         wrBeat, rdBeat;
  logic               inAcc, outAcc, wrLast, rdLast;
  logic [4*WIDTH-1:0] bankData [2];

  assign in_ready  = !full[wrBank];
  assign out_valid = full[rdBank];
  assign out_last  = out_valid && (rdBeat == LastBeat);
  assign out_data  = bankData[rdBank];
  assign busy      = full[0] | full[1] | (wrBeat != 2'd0);

  assign inAcc  = in_valid && in_ready;
  assign outAcc = out_valid && out_ready;
  assign wrLast = inAcc && (wrBeat == LastBeat);
  assign rdLast = outAcc && (rdBeat == LastBeat);

  // The two pointers always address different banks when both edges fire together.
  always_comb begin
    fullNext = full;
    if (wrLast) fullNext[wrBank] = 1'b1;
    if (rdLast) fullNext[rdBank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      wrBank <= 1'b0;
      rdBank <= 1'b0;
      wrBeat <= '0;
      rdBeat <= '0;
    end else begin
      full <= fullNext;
      if (inAcc) begin
        wrBeat <= wrLast ? 2'd0 : wrBeat + 2'd1;
        if (wrLast) wrBank <= !wrBank;
      end
      if (outAcc) begin
        rdBeat <= rdLast ? 2'd0 : rdBeat + 2'd1;
        if (rdLast) rdBank <= !rdBank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : gBank
    coef_tile_bank #(.WIDTH(WIDTH)) uBank (
      .clk    (clk),
      .rst_n  (rst_n),
      .wrEn   (inAcc && (wrBank == 1'(b))),
      .wrRow  (wrBeat),
      .wrData (in_data),
      .wrMode (in_mode),
      .rdBeat (rdBeat),
      .rdData (bankData[b])
    );
  end

endmodule

// File: tb/tb_coef_tile_unpack.sv
// Directed and scoreboard checks for the tile reorder buffer; inputs driven and outputs sampled at negedge.
module tb_coef_tile_unpack;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [1:0]   in_mode;
  logic [127:0] in_data, out_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } expBeat_t;

  always #5 clk = ~clk;

  coef_tile_unpack #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  // Input beat r of a tile: lane c carries base + 16*r + c.
  function automatic logic [127:0] beatIn(input int base, input int r);
    return pack4(base + 16*r, base + 16*r + 1, base + 16*r + 2, base + 16*r + 3);
  endfunction

  function automatic logic [127:0] expTile(input int base, input logic [1:0] mode, input int k);
    int e [4];
    for (int j = 0; j < 4; j++) begin
      if (mode == 2'b01)      e[j] = base + 16*j + k;
      else if (mode == 2'b10) e[j] = base + 16*((j % 2)*2 + j/2) + k;
      else                    e[j] = base + 16*k + j;
    end
    return pack4(e[0], e[1], e[2], e[3]);
  endfunction

  task automatic cycle(input logic iv, input logic [127:0] id, input logic [1:0] im, input logic ordy,
                       output logic ir, output logic ov, output logic [127:0] od, output logic ol);
    in_valid  = iv;
    in_data   = id;
    in_mode   = im;
    out_ready = ordy;
    #1;
    ir = in_ready;
    ov = out_valid;
    od = out_data;
    ol = out_last;
    @(negedge clk);
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = 2'b00;
    rst_n = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_transpose();
    logic ir, ov, ol;
    logic [127:0] od;
    doReset();
    for (int r = 0; r < 4; r++) begin
      cycle(1'b1, beatIn(0, r), 2'b01, 1'b1, ir, ov, od, ol);
      checks++; if (ir !== 1'b1 || ov !== 1'b0) begin
        errors++; $display("FAIL trans_in beat%0d in_ready=%b out_valid=%b want 1/0", r, ir, ov);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 2'b00, 1'b1, ir, ov, od, ol);
      checks++; if (ov !== 1'b1 || od !== pack4(k, 16+k, 32+k, 48+k) || ol !== (k == 3)) begin
        errors++; $display("FAIL trans_out beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                           k, ov, od, ol, pack4(k, 16+k, 32+k, 48+k), (k == 3));
      end
    end
    cycle(1'b0, '0, 2'b00, 1'b1, ir, ov, od, ol);
    checks++; if (ov !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL trans_drain out_valid=%b busy=%b want 0/0", ov, busy);
    end
  endtask

  task automatic test_modes();
    logic ir, ov, ol;
    logic [127:0] od, want;
    logic [1:0] modes [3];
    modes[0] = 2'b10; modes[1] = 2'b00; modes[2] = 2'b11;
    doReset();
    for (int m = 0; m < 3; m++) begin
      for (int r = 0; r < 4; r++) cycle(1'b1, beatIn(0, r), modes[m], 1'b0, ir, ov, od, ol);
      for (int k = 0; k < 4; k++) begin
        cycle(1'b0, '0, 2'b00, 1'b1, ir, ov, od, ol);
        if (modes[m] == 2'b10) want = pack4(k, 32+k, 16+k, 48+k);
        else                   want = pack4(16*k, 16*k+1, 16*k+2, 16*k+3);
        checks++; if (ov !== 1'b1 || od !== want || ol !== (k == 3)) begin
          errors++; $display("FAIL mode%b_out beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             modes[m], k, ov, od, ol, want, (k == 3));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic ir, ov, ol, ninthTaken;
    logic [127:0] od, want;
    int k;
    doReset();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, beatIn(c < 4 ? 0 : 256, c % 4), c < 4 ? 2'b00 : 2'b01, 1'b0, ir, ov, od, ol);
      checks++; if (ir !== 1'b1 || ov !== (c >= 4)) begin
        errors++; $display("FAIL bp_fill cyc%0d in_ready=%b out_valid=%b want 1/%b", c, ir, ov, (c >= 4));
      end
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, beatIn(512, 0), 2'b10, 1'b0, ir, ov, od, ol);
      checks++; if (ir !== 1'b0 || ov !== 1'b1 || od !== pack4(0, 1, 2, 3) || ol !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc%0d in_ready=%b v=%b d=%h l=%b want 0/1/%h/0",
                           c, ir, ov, od, ol, pack4(0, 1, 2, 3));
      end
    end
    ninthTaken = 1'b0;
    for (int r = 0; r < 8; r++) begin
      cycle(!ninthTaken, beatIn(512, 0), 2'b10, 1'b1, ir, ov, od, ol);
      k = r % 4;
      want = (r < 4) ? pack4(16*k, 16*k+1, 16*k+2, 16*k+3) : pack4(256+k, 272+k, 288+k, 304+k);
      checks++; if (ov !== 1'b1 || od !== want || ol !== (k == 3)) begin
        errors++; $display("FAIL bp_drain beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                           r, ov, od, ol, want, (k == 3));
      end
      if (r <= 4) begin
        checks++; if (ir !== (r == 4)) begin
          errors++; $display("FAIL bp_ninth cyc%0d in_ready=%b want %b", r, ir, (r == 4));
        end
      end
      if (!ninthTaken && ir) ninthTaken = 1'b1;
    end
    cycle(1'b0, '0, 2'b00, 1'b1, ir, ov, od, ol);
    checks++; if (ov !== 1'b0 || busy !== 1'b1 || !ninthTaken) begin
      errors++; $display("FAIL bp_end out_valid=%b busy=%b ninth=%b want 0/1/1", ov, busy, ninthTaken);
    end
  endtask

  task automatic test_back_to_back();
    logic ir, ov, ol;
    logic [127:0] od, want;
    logic [1:0] modes [4];
    int t, r;
    modes[0] = 2'b01; modes[1] = 2'b00; modes[2] = 2'b01; modes[3] = 2'b00;
    doReset();
    for (int c = 0; c < 20; c++) begin
      t = c / 4; r = c % 4;
      if (c < 16) cycle(1'b1, beatIn(64*t, r), (r == 0) ? modes[t] : ~modes[t], 1'b1, ir, ov, od, ol);
      else        cycle(1'b0, '0, 2'b00, 1'b1, ir, ov, od, ol);
      if (c < 16) begin
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL b2b_in cyc%0d in_ready=%b want 1", c, ir); end
      end
      if (c < 4) begin
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_early cyc%0d out_valid=%b want 0", c, ov); end
      end else begin
        t = (c - 4) / 4; r = (c - 4) % 4;
        want = expTile(64*t, modes[t], r);
        checks++; if (ov !== 1'b1 || od !== want || ol !== (r == 3)) begin
          errors++; $display("FAIL b2b_out tile%0d beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             t, r, ov, od, ol, want, (r == 3));
        end
      end
    end
  endtask

  task automatic test_random_stalls();
    logic ir, ov, ol, iv, ordy, held, heldL;
    logic [127:0] od, heldD;
    logic [1:0] im, curMode;
    logic [1:0] tileMode [100];
    expBeat_t expQ [$];
    expBeat_t e;
    int wrTile, wrIdx, outCount;
    doReset();
    for (int i = 0; i < 100; i++) tileMode[i] = 2'($urandom_range(0, 3));
    wrTile = 0; wrIdx = 0; outCount = 0; held = 1'b0; heldL = 1'b0; heldD = '0; curMode = 2'b00;
    for (int c = 0; c < 20000 && outCount < 400; c++) begin
      iv   = (wrTile < 100) && ($urandom_range(0, 3) != 0);
      im   = (wrIdx == 0) ? tileMode[wrTile % 100] : 2'($urandom);
      ordy = ($urandom_range(0, 2) != 0);
      cycle(iv, beatIn(64*wrTile, wrIdx), im, ordy, ir, ov, od, ol);
      if (held) begin
        checks++; if (ov !== 1'b1 || od !== heldD || ol !== heldL) begin
          errors++; $display("FAIL stall_stable cyc%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             c, ov, od, ol, heldD, heldL);
        end
      end
      held = ov && !ordy; heldD = od; heldL = ol;
      if (ov && ordy) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("FAIL sb_extra cyc%0d unexpected beat d=%h want none", c, od);
        end else begin
          e = expQ.pop_front();
          if (od !== e.d || ol !== e.l) begin
            errors++; $display("FAIL sb_beat%0d got d=%h l=%b want d=%h l=%b", outCount, od, ol, e.d, e.l);
          end
        end
        outCount++;
      end
      if (iv && ir) begin
        if (wrIdx == 0) curMode = im;
        if (wrIdx == 3) begin
          for (int k = 0; k < 4; k++) begin
            e.d = expTile(64*wrTile, curMode, k);
            e.l = (k == 3);
            expQ.push_back(e);
          end
          wrTile++; wrIdx = 0;
        end else begin
          wrIdx++;
        end
      end
    end
    checks++; if (outCount != 400 || expQ.size() != 0) begin
      errors++; $display("FAIL sb_total got %0d beats (%0d pending) want 400 (0 pending)", outCount, expQ.size());
    end
  endtask

  task automatic test_reset_mid();
    logic ir, ov, ol;
    logic [127:0] od, want;
    doReset();
    for (int r = 0; r < 4; r++) cycle(1'b1, beatIn(1024, r), 2'b01, 1'b0, ir, ov, od, ol);
    for (int r = 0; r < 2; r++) cycle(1'b1, beatIn(1280, r), 2'b00, 1'b0, ir, ov, od, ol);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre busy=%b out_valid=%b want 1/1", busy, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      errors++; $display("FAIL mid_reset v=%b busy=%b rdy=%b last=%b want 0/0/1/0", out_valid, busy, in_ready, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) cycle(1'b1, beatIn(1792, c), 2'b00, 1'b1, ir, ov, od, ol);
      else       cycle(1'b0, '0, 2'b00, 1'b1, ir, ov, od, ol);
      if (c >= 4 && c < 8) begin
        want = pack4(1792 + 16*(c-4), 1793 + 16*(c-4), 1794 + 16*(c-4), 1795 + 16*(c-4));
        checks++; if (ov !== 1'b1 || od !== want || ol !== (c == 7)) begin
          errors++; $display("FAIL mid_after beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             c - 4, ov, od, ol, want, (c == 7));
        end
      end else begin
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_stale cyc%0d out_valid=%b want 0", c, ov); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = 2'b00;
    @(negedge clk);
    test_reset();
    test_transpose();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_random_stalls();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
